// File: rtl/bbox_pixel_iter.sv
// Bounding-box pixel iterator: clips a box to the screen and walks it in raster order (x fastest).
// Latency: first pixel one cycle after the box handshake; then 1 pixel/cycle while rdy_out is high.
// Backpressure: output register holds while rdy_out=0; rdy_in is low for the whole scan and returns one cycle after the last pixel.
`timescale 1ns/1ps
module bbox_pixel_iter #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [4*COORD_W-1:0] data_in,
  output logic                 rdy_in,
  output logic [2*COORD_W-1:0] data_out,
  output logic                 last_out,
  output logic                 vld_out,
  input  logic                 rdy_out,
  output logic                 drop_out
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymax_q;

  logic [COORD_W-1:0] in_xmin, in_ymin, in_xmax, in_ymax;
  logic [COORD_W-1:0] in_xmax_c, in_ymax_c;
  logic               in_empty, in_single;

  logic               row_end;
  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic               nxt_last;

  assign in_xmin = data_in[COORD_W-1:0];
  assign in_ymin = data_in[2*COORD_W-1:COORD_W];
  assign in_xmax = data_in[3*COORD_W-1:2*COORD_W];
  assign in_ymax = data_in[4*COORD_W-1:3*COORD_W];

  assign data_out = {y_q, x_q};

  // Clip the incoming box to the screen and classify it (empty / single pixel).
  always_comb begin
    in_xmax_c = (in_xmax > X_LIM) ? X_LIM : in_xmax;
    in_ymax_c = (in_ymax > Y_LIM) ? Y_LIM : in_ymax;
    in_empty  = (in_xmin > in_xmax_c) || (in_ymin > in_ymax_c);
    in_single = (in_xmin == in_xmax_c) && (in_ymin == in_ymax_c);
  end

  // Next raster position; only used when the current pixel is not the last,
  // so the counters never step past the clipped maxima and cannot wrap.
  always_comb begin
    row_end  = (x_q == xmax_q);
    nxt_x    = row_end ? xmin_q : (x_q + ONE);
    nxt_y    = row_end ? (y_q + ONE) : y_q;
    nxt_last = (nxt_x == xmax_q) && (nxt_y == ymax_q);
  end

  // Control FSM with all outputs registered; vld_out never depends on rdy_out combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_in   <= 1'b1;
      vld_out  <= 1'b0;
      last_out <= 1'b0;
      drop_out <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
    end else begin
      drop_out <= 1'b0;
      case (state)
        IDLE: begin
          if (vld_in && rdy_in) begin
            if (in_empty) begin
              drop_out <= 1'b1;
            end else begin
              xmin_q   <= in_xmin;
              xmax_q   <= in_xmax_c;
              ymax_q   <= in_ymax_c;
              x_q      <= in_xmin;
              y_q      <= in_ymin;
              last_out <= in_single;
              vld_out  <= 1'b1;
              rdy_in   <= 1'b0;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (rdy_out) begin
            if (last_out) begin
              state    <= IDLE;
              vld_out  <= 1'b0;
              last_out <= 1'b0;
              rdy_in   <= 1'b1;
            end else begin
              x_q      <= nxt_x;
              y_q      <= nxt_y;
              last_out <= nxt_last;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_pixel_iter.sv
// Testbench for bbox_pixel_iter: queue-fed upstream, scoreboarded pixel stream, random downstream stalls.
// Latency: checks first pixel one cycle after box handshake and one bubble between boxes.
// Backpressure: rdy_out driven always-high, toggling, or random; output hold checked on every stall.
`timescale 1ns/1ps
module tb_bbox_pixel_iter;

  localparam int CW = 16;
  localparam int SW = 640;
  localparam int SH = 480;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            vld_in = 1'b0;
  logic [4*CW-1:0] data_in = '0;
  logic            rdy_in;
  logic [2*CW-1:0] data_out;
  logic            last_out;
  logic            vld_out;
  logic            rdy_out = 1'b0;
  logic            drop_out;

  bbox_pixel_iter #(.COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_in   (vld_in),
    .data_in  (data_in),
    .rdy_in   (rdy_in),
    .data_out (data_out),
    .last_out (last_out),
    .vld_out  (vld_out),
    .rdy_out  (rdy_out),
    .drop_out (drop_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
    logic          first;
  } pix_t;

  pix_t            exp_q[$];
  logic [4*CW-1:0] fifo_q[$];
  int              drop_exp = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              rdy_mode = 0;
  int              beats = 0;
  int              cyc = 0;
  int              acc_cyc = -10;
  logic            pend_pop = 1'b0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: enumerate the clipped box with nested loops, or count a drop.
  task automatic model_box(input logic [CW-1:0] xmin, input logic [CW-1:0] ymin,
                           input logic [CW-1:0] xmax, input logic [CW-1:0] ymax);
    int xc, yc;
    pix_t p;
    xc = (int'(xmax) > SW - 1) ? SW - 1 : int'(xmax);
    yc = (int'(ymax) > SH - 1) ? SH - 1 : int'(ymax);
    if (int'(xmin) > xc || int'(ymin) > yc) begin
      drop_exp++;
    end else begin
      for (int y = int'(ymin); y <= yc; y++) begin
        for (int x = int'(xmin); x <= xc; x++) begin
          p.x     = CW'(x);
          p.y     = CW'(y);
          p.last  = (x == xc) && (y == yc);
          p.first = (x == int'(xmin)) && (y == int'(ymin));
          exp_q.push_back(p);
        end
      end
    end
  endtask

  // Push a box into the depth-4 upstream queue (waits for space) and into the model.
  task automatic push_box(input logic [CW-1:0] xmin, input logic [CW-1:0] ymin,
                          input logic [CW-1:0] xmax, input logic [CW-1:0] ymax);
    int n;
    n = 0;
    while (fifo_q.size() >= 4 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(fifo_q.size() < 4, "fifo_space", fifo_q.size(), 3);
    model_box(xmin, ymin, xmax, ymax);
    fifo_q.push_back({ymax, xmax, ymin, xmin});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && drop_exp == 0 && fifo_q.size() == 0) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(exp_q.size() == 0 && drop_exp == 0, nm, exp_q.size() + drop_exp, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Upstream queue behaves like a small FIFO: head presented, popped on handshake.
  always @(negedge clk) pend_pop = rst_n && vld_in && rdy_in;

  always @(posedge clk) begin
    if (pend_pop && rst_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #2;
    vld_in  = (fifo_q.size() > 0);
    data_in = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Downstream ready pattern.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_out = 1'b1;
      1:       rdy_out = ~rdy_out;
      default: rdy_out = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: scoreboard pops on every output handshake plus protocol checks.
  logic            p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [2*CW-1:0] p_dat = '0;
  logic            p_hs_nl = 1'b0, p_hs_last = 1'b0;
  pix_t            e;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      p_vld = 1'b0; p_hs_nl = 1'b0; p_hs_last = 1'b0;
    end else begin
      chk(!(vld_out && drop_out), "drop_vld_excl", {vld_out, drop_out}, 0);
      if (p_vld && !p_rdy) begin
        chk(vld_out, "hold_vld", vld_out, 1);
        chk({data_out, last_out} == {p_dat, p_last}, "hold_dat", {data_out, last_out}, {p_dat, p_last});
      end
      if (p_hs_nl) chk(vld_out, "no_gap", vld_out, 1);
      if (p_hs_last) begin
        chk(!vld_out, "bubble_vld", vld_out, 0);
        chk(rdy_in, "bubble_rdy", rdy_in, 1);
      end
      if (vld_out) chk(!rdy_in, "rdy_in_scan", rdy_in, 0);
      if (vld_out && !p_vld && exp_q.size() > 0 && exp_q[0].first)
        chk(cyc == acc_cyc, "first_lat", cyc, acc_cyc);
      if (drop_out) begin
        chk(drop_exp > 0, "drop_expected", drop_exp, 1);
        if (drop_exp > 0) drop_exp--;
        chk(cyc == acc_cyc, "drop_lat", cyc, acc_cyc);
        chk(rdy_in, "drop_rdy", rdy_in, 1);
      end
      p_hs_nl = 1'b0;
      p_hs_last = 1'b0;
      if (vld_out && rdy_out) begin
        chk(exp_q.size() != 0, "unexp_pix", data_out, 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(data_out == {e.y, e.x}, "pix_dat", data_out, {e.y, e.x});
          chk(last_out == e.last, "pix_last", last_out, e.last);
        end
        beats++;
        p_hs_last = last_out;
        p_hs_nl = !last_out;
      end
      if (vld_in && rdy_in) acc_cyc = cyc + 1;
      p_vld = vld_out; p_rdy = rdy_out; p_dat = data_out; p_last = last_out;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d, required 0 pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int base, n;
    logic [CW-1:0] xmn, ymn, xmx, ymx;

    // Reset state (while held in reset).
    repeat (3) @(posedge clk);
    #1;
    chk(rdy_in == 1'b1, "rst_rdy_in", rdy_in, 1);
    chk(vld_out == 1'b0, "rst_vld_out", vld_out, 0);
    chk(last_out == 1'b0, "rst_last_out", last_out, 0);
    chk(drop_out == 1'b0, "rst_drop_out", drop_out, 0);
    chk(data_out == '0, "rst_data_out", data_out, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    rdy_mode = 0; push_box(2, 3, 4, 4); drain("basic_box");
    rdy_mode = 1; push_box(2, 3, 4, 4); drain("toggle_box");
    rdy_mode = 2; push_box(2, 3, 4, 4); drain("stall_box");
    rdy_mode = 0; push_box(638, 479, 700, 900); drain("clip_box");
    push_box(5, 5, 4, 9); push_box(700, 0, 710, 10); drain("degenerate");
    push_box(7, 7, 7, 7); drain("single_px");
    push_box(636, 100, 16'hFFFF, 101); drain("xmax_max");

    // Back-to-back boxes through the depth-4 queue.
    push_box(0, 0, 2, 1); push_box(10, 20, 10, 22); push_box(3, 3, 3, 3); push_box(1, 1, 0, 1);
    push_box(5, 6, 7, 6);
    drain("back_to_back");

    // Random boxes with random stalls.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        xmn = CW'($urandom_range(630, 645));
        xmx = 16'hFFFF;
      end else begin
        xmn = CW'($urandom_range(1, 645));
        xmx = xmn + CW'($urandom_range(0, 6)) - CW'(1);
      end
      ymn = CW'($urandom_range(1, 485));
      ymx = ymn + CW'($urandom_range(0, 5)) - CW'(1);
      push_box(xmn, ymn, xmx, ymx);
    end
    drain("random");

    // Reset mid-scan after 3 beats of a 4x4 box.
    rdy_mode = 0;
    base = beats;
    push_box(0, 0, 3, 3);
    n = 0;
    while (beats < base + 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(beats >= base + 3, "mid_scan_beats", beats - base, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    drop_exp = 0;
    #1;
    chk(vld_out == 1'b0, "async_rst_vld", vld_out, 0);
    chk(rdy_in == 1'b1, "async_rst_rdy", rdy_in, 1);
    chk(last_out == 1'b0, "async_rst_last", last_out, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_box(0, 0, 1, 0);
    drain("post_reset_box");

    chk(exp_q.size() == 0, "final_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
